// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on input and output.
// Results and flags are registered. Multiply is an iterative shift-add engine
// that produces the full double-width product. Divide is a restoring divider
// that produces the quotient and the remainder. Each iterative op runs for
// DATA_WIDTH cycles, and issue is stalled through in_ready while it runs.
//
// Optional build macro: ALU_SEQ_SRA_EN enables opcode 1001, an arithmetic shift
// right of A by B. When the macro is undefined, opcode 1001 is illegal.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE, out of reset
//   inputA, inputB      unsigned operands; B is also the shift amount
//   opcode              operation select
//   out_valid/out_ready result handshake; outputs are held until it completes
//   result, result_hi   primary result and high product / remainder
//   carryout, zero, negative, overflow, div_zero, illegal   registered flags
module alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] inputA,
  input  logic [DATA_WIDTH-1:0] inputB,
  input  logic [3:0]            opcode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  carryout,
  output logic                  zero,
  output logic                  negative,
  output logic                  overflow,
  output logic                  div_zero,
  output logic                  illegal
);
  localparam int W = DATA_WIDTH;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8;
`ifdef ALU_SEQ_SRA_EN
  localparam logic [3:0] OP_SRA = 4'h9;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         ill;
  } sc_t;

  // Every op that completes in one cycle, including the illegal-opcode case.
  // Mul and div never reach this path, so their entries are left at zero.
  function automatic sc_t single_op(input logic [3:0] op,
                                    input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    sc_t            r;
    logic [W:0]     sum;
    logic signed [W-1:0] sa;
    r   = '0;
    sum = '0;
    sa  = a;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        r.res = sum[W-1:0];
        r.co  = sum[W];
        r.ov  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        r.res = a - b;
        r.co  = (a < b);
        r.ov  = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      OP_MUL, OP_DIV: r.res = '0;
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_NOT: r.res = ~a;
      // Shift amounts of DATA_WIDTH or more shift every bit out, giving 0.
      OP_SLL: r.res = a << b;
      OP_SRL: r.res = a >> b;
`ifdef ALU_SEQ_SRA_EN
      OP_SRA: r.res = sa >>> b;
`endif
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]      op_q;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic [W-1:0]    hi_d;
  logic [W-1:0]    lo_d;
  logic [W:0]      msum;
  logic [W:0]      dshift;
  sc_t             sc_now;

  assign sc_now   = single_op(opcode, inputA, inputB);
  assign in_ready = (state_q == S_IDLE) && !rst;

  // Iteration step. For mul, {hi,lo} holds partial product / multiplier.
  // For div, hi is the partial remainder and lo shifts the dividend out while
  // quotient bits shift in. When B is 0, every trial subtraction succeeds. That
  // leaves an all-ones quotient and a remainder equal to A, without any
  // special-case logic.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    msum   = '0;
    dshift = '0;
    if (op_q == OP_MUL) begin
      msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
      hi_d = msum[W:1];
      lo_d = {msum[0], lo_q[W-1:1]};
    end else begin
      dshift = {hi_q, lo_q[W-1]};
      if (dshift >= {1'b0, opb_q}) begin
        dshift = dshift - {1'b0, opb_q};
        lo_d   = {lo_q[W-2:0], 1'b1};
      end else begin
        lo_d   = {lo_q[W-2:0], 1'b0};
      end
      hi_d = dshift[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carryout  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state_q)
        // IDLE: accept operands; single-cycle ops finish on the accept edge.
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= opcode;
            opa_q <= inputA;
            opb_q <= inputB;
            if (opcode == OP_MUL || opcode == OP_DIV) begin
              hi_q    <= '0;
              lo_q    <= (opcode == OP_MUL) ? inputB : inputA;
              cnt_q   <= CNT_W'(W);
              state_q <= S_EXEC;
            end else begin
              result    <= sc_now.res;
              result_hi <= '0;
              carryout  <= sc_now.co;
              overflow  <= sc_now.ov;
              zero      <= (sc_now.res == '0);
              negative  <= sc_now.res[W-1];
              div_zero  <= 1'b0;
              illegal   <= sc_now.ill;
              out_valid <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        // EXEC: one product or quotient bit per cycle; the last step loads outputs.
        S_EXEC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result    <= lo_d;
            result_hi <= hi_d;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= (lo_d == '0);
            negative  <= lo_d[W-1];
            div_zero  <= (op_q == OP_DIV) && (opb_q == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        // DONE: hold outputs until the consumer takes them.
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inputA;
  logic [7:0] inputB;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       carryout, zero, negative, overflow, div_zero, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inputA(inputA), .inputB(inputB), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carryout(carryout),
    .zero(zero), .negative(negative), .overflow(overflow),
    .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic       co;
    logic       ov;
    logic       dz;
    logic       ill;
  } exp_t;

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ia, ib, sa, sb, s;
    e  = '0;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    case (op)
      4'h0: begin s = ia + ib; e.res = 8'(s); e.co = (s > 255);
                  s = sa + sb; e.ov = (s > 127) || (s < -128); end
      4'h1: begin e.res = 8'(ia - ib); e.co = (ia < ib);
                  s = sa - sb; e.ov = (s > 127) || (s < -128); end
      4'h2: begin s = ia * ib; e.res = 8'(s); e.hi = 8'(s / 256); end
      4'h3: begin
        if (ib == 0) begin e.res = 8'hFF; e.hi = a; e.dz = 1'b1; end
        else begin e.res = 8'(ia / ib); e.hi = 8'(ia % ib); end
      end
      4'h4: e.res = a & b;
      4'h5: e.res = a | b;
      4'h6: e.res = ~a;
      4'h7: e.res = (ib >= 8) ? 8'h00 : 8'(ia * (1 << ib));
      4'h8: e.res = (ib >= 8) ? 8'h00 : 8'(ia / (1 << ib));
`ifdef ALU_SEQ_SRA_EN
      4'h9: e.res = (ib >= 8) ? ((sa < 0) ? 8'hFF : 8'h00) : 8'(sa >>> ib);
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op == 4'h2 || op == 4'h3) ? 9 : 1;
  endfunction

  function automatic logic [21:0] expv(input exp_t e);
    return {e.res, e.hi, e.co, (e.res == 8'h00), e.res[7], e.ov, e.dz, e.ill};
  endfunction

  function automatic logic [21:0] obs();
    return {result, result_hi, carryout, zero, negative, overflow, div_zero, illegal};
  endfunction

  // Drive one op and wait for out_valid. lat counts the edges from the accept
  // edge (counted as 1) to the edge after which out_valid is first seen.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic tmo, output logic rdy_busy);
    int guard;
    guard    = 0;
    rdy_busy = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; inputA = a; inputB = b;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    tmo = !out_valid;
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 4'h0; inputA = 8'h00; inputB = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, in_ready, obs()} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got valid=%0b rdy=%0b bus=%h want all 0", out_valid, in_ready, obs());
    end
    @(negedge clk); rst = 1'b0; #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready got %0b want 1", in_ready);
    end
  endtask

  task automatic test_add_sub_hold();
    int lat; logic tmo, rb; logic [21:0] snap;
    issue(4'h0, 8'hF0, 8'h20, lat, tmo, rb);
    n_tests++;
    if (tmo || lat != 1 || result !== 8'h10 || carryout !== 1'b1 || overflow !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_F0_20 got lat=%0d res=%h co=%0b ov=%0b z=%0b want lat=1 res=10 co=1 ov=0 z=0",
               lat, result, carryout, overflow, zero);
    end
    consume();
    issue(4'h1, 8'h80, 8'h01, lat, tmo, rb);
    n_tests++;
    if (tmo || lat != 1 || result !== 8'h7F || carryout !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_80_01 got lat=%0d res=%h co=%0b ov=%0b want lat=1 res=7f co=0 ov=1",
               lat, result, carryout, overflow);
    end
    snap = obs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (obs() !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL sub_hold cyc%0d got bus=%h vld=%0b rdy=%0b want bus=%h vld=1 rdy=0",
                 i, obs(), out_valid, in_ready, snap);
      end
    end
    consume();
  endtask

  task automatic test_mul_div();
    int lat; logic tmo, rb;
    issue(4'h2, 8'hFF, 8'hFF, lat, tmo, rb);
    n_tests++;
    if (tmo || lat != 9 || rb || result_hi !== 8'hFE || result !== 8'h01) begin
      n_fail++;
      $display("FAIL mul_FF_FF got lat=%0d rdy_busy=%0b hi=%h lo=%h want lat=9 rdy_busy=0 hi=fe lo=01",
               lat, rb, result_hi, result);
    end
    consume();
    issue(4'h3, 8'h64, 8'h07, lat, tmo, rb);
    n_tests++;
    if (tmo || lat != 9 || result !== 8'h0E || result_hi !== 8'h02 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL div_64_07 got lat=%0d q=%h r=%h dz=%0b want lat=9 q=0e r=02 dz=0",
               lat, result, result_hi, div_zero);
    end
    consume();
    issue(4'h3, 8'h33, 8'h00, lat, tmo, rb);
    n_tests++;
    if (tmo || lat != 9 || result !== 8'hFF || result_hi !== 8'h33 || div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL div_33_00 got lat=%0d q=%h r=%h dz=%0b want lat=9 q=ff r=33 dz=1",
               lat, result, result_hi, div_zero);
    end
    consume();
  endtask

  task automatic test_reset_abort();
    int lat; logic tmo, rb; logic seen;
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'h2; inputA = 8'h12; inputB = 8'h34;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || obs() !== 22'h0) begin
      n_fail++;
      $display("FAIL abort_in_reset got vld=%0b rdy=%0b bus=%h want 0 0 0", out_valid, in_ready, obs());
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_output got out_valid seen=%0b want 0", seen);
    end
    issue(4'h0, 8'h01, 8'h02, lat, tmo, rb);
    n_tests++;
    if (tmo || lat != 1 || result !== 8'h03) begin
      n_fail++; $display("FAIL abort_then_add got lat=%0d res=%h want lat=1 res=03", lat, result);
    end
    consume();
  endtask

  task automatic test_op9();
    int lat; logic tmo, rb;
    issue(4'h9, 8'h90, 8'h02, lat, tmo, rb);
    n_tests++;
`ifdef ALU_SEQ_SRA_EN
    if (tmo || lat != 1 || result !== 8'hE4 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL sra_90_2 got lat=%0d res=%h ill=%0b want lat=1 res=e4 ill=0", lat, result, illegal);
    end
`else
    if (tmo || lat != 1 || result !== 8'h00 || illegal !== 1'b1 || zero !== 1'b1) begin
      n_fail++; $display("FAIL op9_illegal got lat=%0d res=%h ill=%0b z=%0b want lat=1 res=00 ill=1 z=1",
                         lat, result, illegal, zero);
    end
`endif
    consume();
  endtask

  task automatic test_back_to_back();
    int lat; logic tmo, rb;
    for (int i = 0; i < 4; i++) begin
      issue(4'h5, 8'(i), 8'h10, lat, tmo, rb);
      consume();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready_%0d got vld=%0b rdy=%0b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    int lat, hold; logic tmo, rb; logic [3:0] op; logic [7:0] a, b; exp_t e; logic [21:0] snap;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if ((op >= 4'h7 && op <= 4'h9) && ($urandom_range(0, 3) != 0)) b = 8'($urandom_range(0, 9));
      if (op == 4'h3 && $urandom_range(0, 7) == 0) b = 8'h00;
      e = model(op, a, b);
      issue(op, a, b, lat, tmo, rb);
      n_tests++;
      if (tmo || lat != exp_lat(op) || obs() !== expv(e)) begin
        n_fail++;
        $display("FAIL rand_%0d op=%h a=%h b=%h got lat=%0d bus=%h want lat=%0d bus=%h",
                 i, op, a, b, lat, obs(), exp_lat(op), expv(e));
      end
      hold = $urandom_range(0, 2);
      snap = obs();
      if (hold > 0) begin
        repeat (hold) @(posedge clk);
        #1;
        n_tests++;
        if (obs() !== snap || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL rand_hold_%0d got bus=%h vld=%0b want bus=%h vld=1", i, obs(), out_valid, snap);
        end
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_add_sub_hold();
    test_mul_div();
    test_reset_abort();
    test_op9();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
